// File: rtl/rand_mem_read_relax_module_pkg.sv
// Shared types and default widths for the read-modify (min-relax) stage.
// Optional feature macro: RELAX_FLAG_EN (adds the update flag as data_o MSB).
package rand_mem_read_relax_module_pkg;

  localparam int addr_width  = 64;
  localparam int data_width  = 64;
  localparam int cnt_width   = 32;
  localparam int input_width = addr_width + data_width;
`ifdef RELAX_FLAG_EN
  localparam int output_width = 1 + addr_width + data_width;
`else
  localparam int output_width = addr_width + data_width;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD,
    OUT
  } relax_state_e;

  typedef struct packed {
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] cand;
  } relax_in_t;

  typedef struct packed {
    logic                  flag;
    logic [addr_width-1:0] addr;
    logic [data_width-1:0] result;
  } relax_out_t;

  // Flatten an output item onto the downstream bus; the flag only travels
  // when the write stage is configured to write flagged items only.
  function automatic logic [output_width-1:0] pack_out(input relax_out_t item);
`ifdef RELAX_FLAG_EN
    return item;
`else
    return {item.addr, item.result};
`endif
  endfunction

endpackage

// File: rtl/rand_mem_read_relax_module_relax_min_unit.sv
// Combinational unsigned min-relax: keeps the old word unless the candidate
// is strictly smaller. Ties keep the old word and report no update.
module relax_min_unit #(
  parameter int width = 64
) (
  input  logic [width-1:0] cand,
  input  logic [width-1:0] old,
  output logic             flag,
  output logic [width-1:0] result
);

  // Strict unsigned compare so a tie never counts as an update
  always_comb begin
    flag   = (cand < old);
    result = flag ? cand : old;
  end

endmodule

// File: rtl/rand_mem_read_relax_module.sv
// Read-modify stage feeding the random memory write stage: accepts
// {addr, candidate}, reads the word at addr, min-relaxes it and hands
// {flag, addr, result} downstream. One item in flight, with a read-after-write
// interlock against the last emitted address.
// Optional feature macro: RELAX_FLAG_EN (flag carried as data_o MSB).
module rand_mem_read_relax_module
  import rand_mem_read_relax_module_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [input_width-1:0]  data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic                    mem_read,
  output logic [addr_width-1:0]   mem_addr,
  input  logic [data_width-1:0]   mem_rdata,
  input  logic                    mem_resp,
  output logic [output_width-1:0] data_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [cnt_width-1:0]    update_count
);

  relax_state_e          state_q;
  relax_state_e          state_d;
  relax_in_t             in_item;
  relax_out_t            out_item;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] cand_q;
  logic [data_width-1:0] old_q;
  logic [addr_width-1:0] hz_addr_q;
  logic                  hz_valid_q;
  logic [cnt_width-1:0]  count_q;
  logic                  hazard;
  logic                  relax_flag;
  logic [data_width-1:0] relax_result;

  assign in_item = data_i;

  relax_min_unit #(
    .width(data_width)
  ) u_relax_min (
    .cand  (cand_q),
    .old   (old_q),
    .flag  (relax_flag),
    .result(relax_result)
  );

  // The downstream write of the last emitted address may still be pending
  // while ready_i is low; reading that address now would return stale data.
  always_comb begin
    hazard = hz_valid_q & (addr_q == hz_addr_q) & ~ready_i;
  end

  // Output item is built purely from held registers, so it is stable in OUT
  always_comb begin
    out_item        = '0;
    out_item.flag   = relax_flag;
    out_item.addr   = addr_q;
    out_item.result = relax_result;
  end

  assign data_o       = pack_out(out_item);
  assign mem_addr     = addr_q;
  assign update_count = count_q;

  // State register plus the item, old-word, hazard and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cand_q     <= '0;
      old_q      <= '0;
      hz_addr_q  <= '0;
      hz_valid_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            addr_q <= in_item.addr;
            cand_q <= in_item.cand;
          end
          if (ready_i) begin
            hz_valid_q <= 1'b0;
          end
        end
        RD: begin
          if (mem_resp) begin
            old_q <= mem_rdata;
          end
          if (ready_i) begin
            hz_valid_q <= 1'b0;
          end
        end
        OUT: begin
          if (ready_i) begin
            hz_addr_q  <= addr_q;
            hz_valid_q <= 1'b1;
            if (relax_flag) begin
              count_q <= count_q + 1'b1;
            end
          end
        end
        default: begin
          hz_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Next-state and handshake/memory-request outputs
  always_comb begin
    state_d  = state_q;
    ready_o  = 1'b0;
    mem_read = 1'b0;
    valid_o  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = RD;
        end
      end
      RD: begin
        mem_read = ~hazard;
        if (mem_resp) begin
          state_d = OUT;
        end
      end
      OUT: begin
        valid_o = 1'b1;
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rand_mem_read_relax_module.sv
// Directed bench for the min-relax read-modify stage.
module tb_rand_mem_read_relax_module;
  import rand_mem_read_relax_module_pkg::*;

  logic                    clk;
  logic                    rst;
  logic [input_width-1:0]  data_i;
  logic                    valid_i;
  logic                    ready_o;
  logic                    mem_read;
  logic [addr_width-1:0]   mem_addr;
  logic [data_width-1:0]   mem_rdata;
  logic                    mem_resp;
  logic [output_width-1:0] data_o;
  logic                    valid_o;
  logic                    ready_i;
  logic [cnt_width-1:0]    update_count;

  int n_compared;
  int n_mismatched;

  rand_mem_read_relax_module dut (
    .clk         (clk),
    .rst         (rst),
    .data_i      (data_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .update_count(update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected downstream word from hand-computed flag/addr/result
  function automatic logic [output_width-1:0] exp_out(input logic flag,
                                                       input logic [63:0] addr,
                                                       input logic [63:0] res);
`ifdef RELAX_FLAG_EN
    return {flag, addr, res};
`else
    return {addr, res} | {output_width{flag & 1'b0}};
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_item(input logic [63:0] addr, input logic [63:0] cand);
    data_i  = {addr, cand};
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic respond(input logic [63:0] old, input int lat);
    for (int i = 0; i < lat - 1; i++) tick();
    mem_rdata = old;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_compared++; if (ready_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_ready_o: got %b want 1", ready_o); end
    n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_mem_read: got %b want 0", mem_read); end
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_valid_o: got %b want 0", valid_o); end
    n_compared++; if (mem_addr !== 64'd0) begin n_mismatched++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_compared++; if (data_o !== '0) begin n_mismatched++; $display("[TB] FAIL reset_data_o: got %h want 0", data_o); end
    n_compared++; if (update_count !== 32'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", update_count); end
  endtask

  task automatic test_basic_update();
    accept_item(64'h10, 64'd5);
    n_compared++; if (ready_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_ready_rd: got %b want 0", ready_o); end
    for (int i = 0; i < 2; i++) begin
      n_compared++; if (mem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_mem_read[%0d]: got %b want 1", i, mem_read); end
      n_compared++; if (mem_addr !== 64'h10) begin n_mismatched++; $display("[TB] FAIL basic_mem_addr[%0d]: got %h want 10", i, mem_addr); end
      tick();
    end
    mem_rdata = 64'd9;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
    n_compared++; if (valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_valid_o: got %b want 1", valid_o); end
    n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_read_off: got %b want 0", mem_read); end
    n_compared++; if (data_o !== exp_out(1'b1, 64'h10, 64'd5)) begin n_mismatched++; $display("[TB] FAIL basic_data_o: got %h want %h", data_o, exp_out(1'b1, 64'h10, 64'd5)); end
    tick();
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL basic_valid_drop: got %b want 0", valid_o); end
    n_compared++; if (ready_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL basic_ready_back: got %b want 1", ready_o); end
    n_compared++; if (update_count !== 32'd1) begin n_mismatched++; $display("[TB] FAIL basic_count: got %0d want 1", update_count); end
  endtask

  task automatic test_no_update();
    accept_item(64'h30, 64'd9);
    respond(64'd9, 2);
    n_compared++; if (data_o !== exp_out(1'b0, 64'h30, 64'd9)) begin n_mismatched++; $display("[TB] FAIL tie_data_o: got %h want %h", data_o, exp_out(1'b0, 64'h30, 64'd9)); end
    tick();
    accept_item(64'h34, 64'd12);
    respond(64'd9, 1);
    n_compared++; if (data_o !== exp_out(1'b0, 64'h34, 64'd9)) begin n_mismatched++; $display("[TB] FAIL greater_data_o: got %h want %h", data_o, exp_out(1'b0, 64'h34, 64'd9)); end
    tick();
    n_compared++; if (update_count !== 32'd1) begin n_mismatched++; $display("[TB] FAIL no_update_count: got %0d want 1", update_count); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    accept_item(64'h40, 64'd2);
    respond(64'd6, 2);
    data_i  = {64'h44, 64'd1};
    valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_compared++; if (valid_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", i, valid_o); end
      n_compared++; if (data_o !== exp_out(1'b1, 64'h40, 64'd2)) begin n_mismatched++; $display("[TB] FAIL bp_data[%0d]: got %h want %h", i, data_o, exp_out(1'b1, 64'h40, 64'd2)); end
      n_compared++; if (ready_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL bp_ready[%0d]: got %b want 0", i, ready_o); end
      tick();
    end
    ready_i = 1'b1;
    tick();
    n_compared++; if (ready_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_ready_after: got %b want 1", ready_o); end
    n_compared++; if (update_count !== 32'd2) begin n_mismatched++; $display("[TB] FAIL bp_count: got %0d want 2", update_count); end
    tick();
    valid_i = 1'b0;
    n_compared++; if (mem_addr !== 64'h44 || mem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL bp_next_accept: got addr %h read %b want 44/1", mem_addr, mem_read); end
    respond(64'd1, 1);
    n_compared++; if (data_o !== exp_out(1'b0, 64'h44, 64'd1)) begin n_mismatched++; $display("[TB] FAIL bp_next_data: got %h want %h", data_o, exp_out(1'b0, 64'h44, 64'd1)); end
    tick();
  endtask

  task automatic test_hazard();
    accept_item(64'h20, 64'd3);
    respond(64'd8, 1);
    tick();
    ready_i = 1'b0;
    accept_item(64'h20, 64'd8);
    for (int i = 0; i < 3; i++) begin
      n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL hz_stall[%0d]: got %b want 0", i, mem_read); end
      tick();
    end
    ready_i = 1'b1;
    #1;
    n_compared++; if (mem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hz_release: got %b want 1", mem_read); end
    tick();
    ready_i = 1'b0;
    n_compared++; if (mem_read !== 1'b1) begin n_mismatched++; $display("[TB] FAIL hz_cleared: got %b want 1", mem_read); end
    ready_i = 1'b1;
    respond(64'd8, 1);
    tick();
    ready_i = 1'b0;
    accept_item(64'h24, 64'd8);
    n_compared++; if (mem_read !== 1'b1 || mem_addr !== 64'h24) begin n_mismatched++; $display("[TB] FAIL hz_other_addr: got read %b addr %h want 1/24", mem_read, mem_addr); end
    respond(64'd8, 1);
    ready_i = 1'b1;
    tick();
    n_compared++; if (update_count !== 32'd3) begin n_mismatched++; $display("[TB] FAIL hz_count: got %0d want 3", update_count); end
  endtask

  task automatic test_reset_mid_rd();
    accept_item(64'h50, 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_compared++; if (ready_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_ready: got %b want 1", ready_o); end
    n_compared++; if (mem_read !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_mem_read: got %b want 0", mem_read); end
    n_compared++; if (valid_o !== 1'b0) begin n_mismatched++; $display("[TB] FAIL rmid_valid: got %b want 0", valid_o); end
    n_compared++; if (update_count !== 32'd0) begin n_mismatched++; $display("[TB] FAIL rmid_count: got %0d want 0", update_count); end
    n_compared++; if (mem_addr !== 64'd0) begin n_mismatched++; $display("[TB] FAIL rmid_mem_addr: got %h want 0", mem_addr); end
    mem_rdata = 64'd4;
    mem_resp  = 1'b1;
    tick();
    mem_resp  = 1'b0;
    n_compared++; if (valid_o !== 1'b0 || ready_o !== 1'b1) begin n_mismatched++; $display("[TB] FAIL rmid_stray_resp: got valid %b ready %b want 0/1", valid_o, ready_o); end
    accept_item(64'h60, 64'd3);
    respond(64'd7, 2);
    n_compared++; if (data_o !== exp_out(1'b1, 64'h60, 64'd3)) begin n_mismatched++; $display("[TB] FAIL min_cand_data: got %h want %h", data_o, exp_out(1'b1, 64'h60, 64'd3)); end
    tick();
    accept_item(64'h64, 64'd8);
    respond(64'd7, 2);
    n_compared++; if (data_o !== exp_out(1'b0, 64'h64, 64'd7)) begin n_mismatched++; $display("[TB] FAIL min_old_data: got %h want %h", data_o, exp_out(1'b0, 64'h64, 64'd7)); end
    tick();
    n_compared++; if (update_count !== 32'd1) begin n_mismatched++; $display("[TB] FAIL post_reset_count: got %0d want 1", update_count); end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b1;
    data_i    = '0;
    valid_i   = 1'b0;
    mem_rdata = '0;
    mem_resp  = 1'b0;
    ready_i   = 1'b1;
    test_reset();
    test_basic_update();
    test_no_update();
    test_backpressure();
    test_hazard();
    test_reset_mid_rd();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
